// File: rtl/vga_pkg.sv
`default_nettype none
// ==================================================================
// vga_pkg : frame-buffer geometry, arbiter states and bus decode
// Rev 1.0
// ==================================================================
package vga_pkg;

  localparam int VGA_WIDTH  = 320;
  localparam int VGA_HEIGHT = 240;
  localparam int FB_DEPTH   = VGA_WIDTH * VGA_HEIGHT;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    DONE    = 2'd2
  } fb_arb_state_t;

  // Misaligned, beyond the frame buffer, or asking to read and write at once.
  function automatic logic fb_decode_err(
    input logic [1:0]  byte_off,
    input logic [63:0] word_idx,
    input logic [63:0] depth,
    input logic        wen,
    input logic        ren
  );
    return (byte_off != 2'b00) || (word_idx >= depth) || (wen && ren);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ==================================================================
// vga_fb_arbiter : scanout-priority arbiter for a single-port frame
//                  buffer RAM, with a starvation guard for bus access
// Rev 1.0
// ==================================================================
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int FB_DEPTH     = vga_pkg::FB_DEPTH,
  parameter int MEM_AW       = $clog2(FB_DEPTH),
  parameter int MAX_SCAN_RUN = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scan_req,
  input  logic [MEM_AW-1:0]     scan_addr,
  output logic                  scan_gnt,
  output logic                  scan_rvalid,
  output logic [DATA_WIDTH-1:0] scan_rdata,
  input  logic                  bus_wen,
  input  logic                  bus_ren,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  input  logic [DATA_WIDTH-1:0] bus_wdata,
  output logic                  bus_stall,
  output logic                  bus_error,
  output logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int              RUN_W   = $clog2(MAX_SCAN_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_SCAN_RUN);

  fb_arb_state_t         state_q, state_d;
  logic [RUN_W-1:0]      run_q, run_d;
  logic                  scan_rvalid_q, scan_rvalid_d;
  logic [DATA_WIDTH-1:0] bus_rdata_q, bus_rdata_d;
  logic                  bus_error_q, bus_error_d;

  logic                  bus_req;
  logic                  dec_err;
  logic                  bus_win;
  logic [ADDR_WIDTH-1:0] word_idx;

  assign bus_req  = bus_wen | bus_ren;
  assign word_idx = bus_addr >> 2;
  assign dec_err  = fb_decode_err(bus_addr[1:0], 64'(word_idx), 64'(FB_DEPTH),
                                  bus_wen, bus_ren);

  assign bus_stall   = bus_req & (state_q != DONE);
  assign bus_error   = bus_error_q;
  assign bus_rdata   = bus_rdata_q;
  assign scan_rvalid = scan_rvalid_q;
  // RAM output register already provides the one-cycle pipeline stage.
  assign scan_rdata  = scan_rvalid_q ? mem_rdata : '0;

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    bus_rdata_d = bus_rdata_q;
    bus_error_d = bus_error_q;
    bus_win     = 1'b0;
    scan_gnt    = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;

    unique case (state_q)
      IDLE: begin
        if (!rst && bus_req && (!scan_req || run_q == RUN_MAX)) begin
          bus_win     = 1'b1;
          bus_error_d = dec_err;
          run_d       = '0;
          if (dec_err) begin
            state_d = DONE;
          end else begin
            mem_en   = 1'b1;
            mem_we   = bus_wen;
            mem_addr = word_idx[MEM_AW-1:0];
            if (bus_wen) begin
              mem_wdata = bus_wdata;
              state_d   = DONE;
            end else begin
              state_d = RD_WAIT;
            end
          end
        end
      end
      RD_WAIT: begin
        bus_rdata_d = mem_rdata;
        state_d     = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Scanout takes every slot the bus did not win, including RD_WAIT and DONE.
    if (!rst && scan_req && !bus_win) begin
      scan_gnt = 1'b1;
      mem_en   = 1'b1;
      mem_addr = scan_addr;
      if (state_q == IDLE && bus_req && run_q != RUN_MAX) run_d = run_q + 1'b1;
    end

    if (!bus_req) run_d = '0;
    scan_rvalid_d = scan_gnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      run_q         <= '0;
      scan_rvalid_q <= 1'b0;
      bus_rdata_q   <= '0;
      bus_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      run_q         <= run_d;
      scan_rvalid_q <= scan_rvalid_d;
      bus_rdata_q   <= bus_rdata_d;
      bus_error_q   <= bus_error_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// ==================================================================
// tb_vga_fb_arbiter : directed vectors, corner sequences and random
//                     traffic against a transaction-level model
// Rev 1.0
// ==================================================================
module tb_vga_fb_arbiter;

  localparam int FB_DEPTH     = 76800;
  localparam int MEM_AW       = 17;
  localparam int MAX_SCAN_RUN = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              scan_req;
  logic [MEM_AW-1:0] scan_addr;
  logic              scan_gnt, scan_rvalid;
  logic [31:0]       scan_rdata;
  logic              bus_wen, bus_ren;
  logic [31:0]       bus_addr, bus_wdata;
  logic              bus_stall, bus_error;
  logic [31:0]       bus_rdata;
  logic              mem_en, mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = '0;

  vga_fb_arbiter dut (
    .clk(clk), .rst(rst),
    .scan_req(scan_req), .scan_addr(scan_addr), .scan_gnt(scan_gnt),
    .scan_rvalid(scan_rvalid), .scan_rdata(scan_rdata),
    .bus_wen(bus_wen), .bus_ren(bus_ren), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_stall(bus_stall), .bus_error(bus_error), .bus_rdata(bus_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [31:0] i);
    return (i * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  // Frame-buffer RAM: synchronous, one-cycle read latency.
  logic [31:0] ram    [FB_DEPTH];
  bit          ram_wr [FB_DEPTH];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]    <= mem_wdata;
        ram_wr[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : init_val(32'(mem_addr));
      end
    end
  end

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: contents, one outstanding bus op, scan-streak length.
  logic [31:0] shadow [FB_DEPTH];
  bit          sh_wr  [FB_DEPTH];
  int          m_left;          // cycles until the outstanding op completes, -1 = none
  int          m_streak;        // scan grants while the bus waited
  bit          m_err, m_rd;
  logic [31:0] m_rdata;
  bit          e_rvalid;
  logic [31:0] e_sdata;

  bit          s_gnt, s_stall, s_wr, s_rv, s_err;
  logic [31:0] s_sd, s_rdata;

  function automatic logic [31:0] mread(input logic [31:0] i);
    return sh_wr[i] ? shadow[i] : init_val(i);
  endfunction

  task automatic model_reset();
    m_left = -1; m_streak = 0; m_err = 0; m_rd = 0; m_rdata = '0;
    e_rvalid = 0; e_sdata = '0;
  endtask

  // One clock: check this cycle's outputs against the model, then advance it.
  task automatic cycle();
    logic        req, err, done_now, free, bus_go, scan_go;
    logic [31:0] idx;
    #1;
    req      = bus_wen | bus_ren;
    idx      = bus_addr >> 2;
    err      = (bus_addr[1:0] != 2'b00) || (idx >= FB_DEPTH) || (bus_wen && bus_ren);
    done_now = (m_left == 0);
    free     = (m_left < 0);
    bus_go   = free && req && (!scan_req || m_streak >= MAX_SCAN_RUN);
    scan_go  = scan_req && !bus_go;

    chk("bus_stall", bus_stall, req && !done_now);
    chk("scan_gnt", scan_gnt, scan_go);
    chk("mem_en", mem_en, scan_go || (bus_go && !err));
    chk("mem_we", mem_we, bus_go && !err && bus_wen);
    if (scan_go) chk("mem_addr_scan", mem_addr, scan_addr);
    else if (bus_go && !err) begin
      chk("mem_addr_bus", mem_addr, idx);
      if (bus_wen) chk("mem_wdata", mem_wdata, bus_wdata);
    end
    chk("scan_rvalid", scan_rvalid, e_rvalid);
    if (e_rvalid) chk("scan_rdata", scan_rdata, e_sdata);
    if (done_now) begin
      chk("bus_error", bus_error, m_err);
      if (m_rd) chk("bus_rdata", bus_rdata, m_rdata);
    end

    s_gnt = scan_gnt; s_stall = bus_stall; s_wr = mem_en && mem_we;
    s_rv = scan_rvalid; s_sd = scan_rdata; s_err = bus_error; s_rdata = bus_rdata;

    @(posedge clk);
    e_rvalid = scan_go;
    if (scan_go) e_sdata = mread(32'(scan_addr));
    if (m_left >= 0) m_left--;
    if (bus_go) begin
      m_err    = err;
      m_rd     = bus_ren && !err;
      if (m_rd) m_rdata = mread(idx);
      if (!err && bus_wen) begin shadow[idx] = bus_wdata; sh_wr[idx] = 1'b1; end
      m_left   = m_rd ? 1 : 0;
      m_streak = 0;
    end else if (!req) m_streak = 0;
    else if (scan_go && free && m_streak < MAX_SCAN_RUN) m_streak++;
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_scan_gnt", scan_gnt, 0);
    chk("rst_scan_rvalid", scan_rvalid, 0);
    chk("rst_scan_rdata", scan_rdata, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_bus_error", bus_error, 0);
    chk("rst_bus_rdata", bus_rdata, 0);
    chk("rst_bus_stall", bus_stall, bus_wen | bus_ren);
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic bus_op(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output bit err, output logic [31:0] rd);
    bus_wen = w; bus_ren = r; bus_addr = a; bus_wdata = d;
    lat = 0;
    do begin
      cycle();
      lat++;
    end while (s_stall && lat < 10);
    err = s_err; rd = s_rdata;
    bus_wen = 0; bus_ren = 0;
    lat = lat - 1;
  endtask

  typedef struct {
    bit          w, r;
    logic [31:0] a, d;
    bit          err;
    logic [31:0] rd;
    int          lat;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, cyc, nw, gcount;
    bit          err;
    logic [31:0] rd;
    int          gaps [3];

    rst = 1'b1; scan_req = 0; scan_addr = '0;
    bus_wen = 0; bus_ren = 0; bus_addr = '0; bus_wdata = '0;
    model_reset();

    vecs[0] = '{1, 0, 32'h0000_0100, 32'hA5A5_A5A5, 0, 32'h0,          1};
    vecs[1] = '{0, 1, 32'h0000_0100, 32'h0,         0, 32'hA5A5_A5A5, 2};
    vecs[2] = '{1, 0, 32'h0004_B000, 32'h1234_5678, 1, 32'h0,          1};
    vecs[3] = '{0, 1, 32'h0000_0002, 32'h0,         1, 32'h0,          1};
    vecs[4] = '{1, 1, 32'h0000_0200, 32'h0,         1, 32'h0,          1};
    vecs[5] = '{0, 1, 32'h0004_AFFC, 32'h0,         0, init_val(32'd76799), 2};
    vecs[6] = '{1, 0, 32'h0004_AFFC, 32'hDEAD_BEEF, 0, 32'h0,          1};
    vecs[7] = '{0, 1, 32'h0004_AFFC, 32'h0,         0, 32'hDEAD_BEEF, 2};
    vecs[8] = '{0, 1, 32'h0004_B004, 32'h0,         1, 32'h0,          1};

    @(posedge clk); #2;
    do_reset();

    foreach (vecs[i]) begin
      bus_op(vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].d, lat, err, rd);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_err", i), err, vecs[i].err);
      if (vecs[i].r && !vecs[i].err) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rd);
      cycle();
    end

    // Scan read pipeline on back-to-back grants.
    bus_op(1, 0, 32'h14, 32'h11, lat, err, rd);
    bus_op(1, 0, 32'h18, 32'h22, lat, err, rd);
    cycle();
    scan_req = 1; scan_addr = 5;
    cycle();
    chk("pipe_gnt0", s_gnt, 1);
    scan_addr = 6;
    cycle();
    chk("pipe_gnt1", s_gnt, 1);
    chk("pipe_rv0", s_rv, 1);
    chk("pipe_d0", s_sd, 32'h11);
    scan_req = 0;
    cycle();
    chk("pipe_rv1", s_rv, 1);
    chk("pipe_d1", s_sd, 32'h22);

    // Starvation guard under continuous scan and write traffic.
    scan_req = 1; scan_addr = 100;
    bus_wen = 1; bus_addr = 32'h400; bus_wdata = 32'hC0FF_EE00;
    gcount = 0; nw = 0; cyc = 0;
    while (nw < 3 && cyc < 100) begin
      cycle();
      cyc++;
      if (s_wr) begin
        chk("starve_gnt_on_write", s_gnt, 0);
        gaps[nw] = gcount; gcount = 0; nw++;
      end
      if (s_gnt) begin gcount++; scan_addr = scan_addr + 1'b1; end
      if (!s_stall) begin bus_addr = bus_addr + 4; bus_wdata = bus_wdata + 1; end
    end
    chk("starve_writes", nw, 3);
    chk("starve_gap0", gaps[0], 4);
    chk("starve_gap1", gaps[1], 5);
    chk("starve_gap2", gaps[2], 5);
    cycle();
    scan_req = 0; bus_wen = 0;
    cycle();

    // Reset while a bus read is in RD_WAIT; the held request is reissued.
    bus_ren = 1; bus_addr = 32'h100;
    cycle();
    do_reset();
    lat = 0;
    do begin cycle(); lat++; end while (s_stall && lat < 10);
    chk("rst_reissue_lat", lat - 1, 2);
    chk("rst_reissue_rdata", s_rdata, 32'hA5A5_A5A5);
    bus_ren = 0;
    cycle();

    // Scan wins a simultaneous request; the bus goes the cycle scan drops.
    scan_req = 1; scan_addr = 9;
    bus_wen = 1; bus_addr = 32'h40; bus_wdata = 32'h0BAD_F00D;
    cycle();
    chk("simul_gnt0", s_gnt, 1);
    chk("simul_wr0", s_wr, 0);
    scan_addr = 10;
    cycle();
    chk("simul_gnt1", s_gnt, 1);
    scan_req = 0;
    cycle();
    chk("simul_bus_issue", s_wr, 1);
    cycle();
    bus_wen = 0;
    cycle();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      cycle();
      if (scan_req && s_gnt) scan_req = 0;
      if (!scan_req && ($urandom % 4 != 0)) begin
        scan_req  = 1;
        scan_addr = MEM_AW'($urandom_range(0, FB_DEPTH - 1));
      end
      if ((bus_wen || bus_ren) && !s_stall) begin
        bus_wen = 0; bus_ren = 0;
      end else if (!(bus_wen || bus_ren) && ($urandom % 3 == 0)) begin
        int unsigned k, ix;
        k  = $urandom % 10;
        ix = ($urandom % 2) ? $urandom_range(0, 31) : $urandom_range(FB_DEPTH - 16, FB_DEPTH - 1);
        bus_addr  = ix << 2;
        bus_wdata = $urandom;
        bus_wen   = (k < 4);
        bus_ren   = (k >= 4 && k < 8);
        if (k == 8) begin
          bus_addr = bus_addr | 32'($urandom_range(1, 3));
          bus_ren  = 1;
        end else if (k == 9) begin
          if ($urandom % 2) begin bus_wen = 1; bus_ren = 1; end
          else begin bus_addr = (FB_DEPTH + $urandom_range(0, 100)) << 2; bus_wen = 1; end
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
